// File: rtl/dm_responder_if.sv
// Processor-side bus bundle for dm_responder: request/write-data inputs and ack/read-data outputs.
// The byte-lane enable signal exists only when DM_BYTE_WRITE_EN is defined.
interface dm_responder_if;
  logic        req;
  logic        in;
  logic [11:2] add_dm;
  logic [31:0] dm_in;
`ifdef DM_BYTE_WRITE_EN
  logic [3:0]  be;
`endif
  logic        ack;
  logic [31:0] dm_out;
  logic        busy;

`ifdef DM_BYTE_WRITE_EN
  modport master (output req, in, add_dm, dm_in, be, input ack, dm_out, busy);
  modport slave  (input req, in, add_dm, dm_in, be, output ack, dm_out, busy);
`else
  modport master (output req, in, add_dm, dm_in, input ack, dm_out, busy);
  modport slave  (input req, in, add_dm, dm_in, output ack, dm_out, busy);
`endif
endinterface

// File: rtl/dm_responder.sv
// Fixed-latency 1024x32 data-memory responder: IDLE -> WAIT (LATENCY cycles) -> RESP (one-cycle ack).
// Optional macro DM_BYTE_WRITE_EN adds per-byte write enables on the bus.
module dm_responder #(
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  dm_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic [9:0]  addr_reg;
  logic [31:0] wdata_reg;
  logic        wr_reg;
  logic [3:0]  be_reg;
  logic [3:0]  be_in;
  logic        accept;
  logic        access_en;
  logic        wr_en;
  logic        rd_en;
  logic [3:0][7:0] dout_lanes;

`ifdef DM_BYTE_WRITE_EN
  assign be_in = bus.be;
`else
  assign be_in = 4'hF;
`endif

  assign accept    = (state_reg == IDLE) && bus.req;
  // Reset at the access edge must also cancel the memory write and the read-data load.
  assign access_en = (state_reg == WAIT) && (cnt_reg == 4'd0) && !reset;
  assign wr_en     = access_en && wr_reg;
  assign rd_en     = access_en && !wr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (bus.req) state_next = WAIT;
      WAIT:    if (cnt_reg == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ack  = 1'b0;
    bus.busy = 1'b0;
    unique case (state_reg)
      IDLE:    ;
      WAIT:    bus.busy = 1'b1;
      RESP:    begin
        bus.ack  = 1'b1;
        bus.busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Request fields are frozen at acceptance so later bus activity cannot disturb the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= 4'd0;
      addr_reg  <= 10'd0;
      wdata_reg <= 32'd0;
      wr_reg    <= 1'b0;
      be_reg    <= 4'd0;
    end else if (accept) begin
      cnt_reg   <= LAT_M1;
      addr_reg  <= bus.add_dm;
      wdata_reg <= bus.dm_in;
      wr_reg    <= bus.in;
      be_reg    <= be_in;
    end else if ((state_reg == WAIT) && (cnt_reg != 4'd0)) begin
      cnt_reg <= cnt_reg - 4'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [0:1023];
      logic [7:0] dout_byte_reg;

      always_ff @(posedge clk) begin
        if (wr_en && be_reg[gi]) begin
          mem[addr_reg] <= wdata_reg[gi*8 +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          dout_byte_reg <= 8'd0;
        end else if (rd_en) begin
          dout_byte_reg <= mem[addr_reg];
        end
      end

      assign dout_lanes[gi] = dout_byte_reg;
    end
  endgenerate

  assign bus.dm_out = dout_lanes;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: table of single transactions at LATENCY=2 plus
// hand-written reset-abort, input-interference and LATENCY=1/15 throughput sequences.
module tb_dm_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_responder_if bus2 ();
  dm_responder_if bus1 ();
  dm_responder_if bus15 ();

  dm_responder #(.LATENCY(2))  dut2  (.clk(clk), .reset(reset), .bus(bus2.slave));
  dm_responder #(.LATENCY(1))  dut1  (.clk(clk), .reset(reset), .bus(bus1.slave));
  dm_responder #(.LATENCY(15)) dut15 (.clk(clk), .reset(reset), .bus(bus15.slave));

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic wr, input logic [9:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input logic [31:0] exp_dout);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.be = be; v.exp_dout = exp_dout;
    vecs.push_back(v);
  endtask

  task automatic drive_req(input logic wr, input logic [9:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
    @(negedge clk);
    bus2.req    = 1'b1;
    bus2.in     = wr;
    bus2.add_dm = addr;
    bus2.dm_in  = data;
`ifdef DM_BYTE_WRITE_EN
    bus2.be     = be;
`else
    if (be != 4'hF) $display("note: be=%b ignored in full-word build", be);
`endif
  endtask

  // LATENCY=2: ack only after edge E2, busy after E0..E2, idle after E3.
  task automatic run_txn(input int idx, input vec_t v);
    drive_req(v.wr, v.addr, v.data, v.be);
    @(posedge clk); #1;
    bus2.req = 1'b0;
    check($sformatf("vec%0d_busy_e0", idx), 32'(bus2.busy), 32'd1);
    check($sformatf("vec%0d_ack_e0", idx), 32'(bus2.ack), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("vec%0d_ack_e%0d", idx, k), 32'(bus2.ack), 32'(k == 2));
      check($sformatf("vec%0d_busy_e%0d", idx, k), 32'(bus2.busy), 32'(k <= 2));
      if (k >= 2) check($sformatf("vec%0d_dout_e%0d", idx, k), bus2.dm_out, v.exp_dout);
    end
    $display("txn %0d %s addr=%0d data=%h be=%b dm_out=%h", idx, v.wr ? "WR" : "RD",
             v.addr, v.data, v.be, bus2.dm_out);
  endtask

  initial begin
    int   acks;
    int   t1[8];
    int   t15[8];
    int   n1;
    int   n15;
    vec_t v;

    reset = 1'b1;
    bus2.req = 1'b0;  bus2.in = 1'b0;  bus2.add_dm = '0;  bus2.dm_in = '0;
    bus1.req = 1'b0;  bus1.in = 1'b1;  bus1.add_dm = '0;  bus1.dm_in = 32'h1;
    bus15.req = 1'b0; bus15.in = 1'b1; bus15.add_dm = '0; bus15.dm_in = 32'h2;
`ifdef DM_BYTE_WRITE_EN
    bus2.be = 4'hF; bus1.be = 4'hF; bus15.be = 4'hF;
`endif
    // req asserted during reset must be ignored
    @(negedge clk); bus2.req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy2", 32'(bus2.busy), 32'd0);
    check("rst_ack2", 32'(bus2.ack), 32'd0);
    check("rst_dout2", bus2.dm_out, 32'd0);
    check("rst_busy1", 32'(bus1.busy), 32'd0);
    check("rst_busy15", 32'(bus15.busy), 32'd0);
    @(negedge clk); bus2.req = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    check("idle_busy2", 32'(bus2.busy), 32'd0);

    add_vec(1'b1, 10'd5,    32'h12345678, 4'hF, 32'h00000000);
    add_vec(1'b0, 10'd5,    32'h00000000, 4'hF, 32'h12345678);
    add_vec(1'b1, 10'd6,    32'h0BADC0DE, 4'hF, 32'h12345678);
    add_vec(1'b1, 10'd7,    32'h77777777, 4'hF, 32'h12345678);
    add_vec(1'b1, 10'd8,    32'h88888888, 4'hF, 32'h12345678);
    add_vec(1'b1, 10'd1023, 32'hCAFEF00D, 4'hF, 32'h12345678);
    add_vec(1'b1, 10'd0,    32'h00000001, 4'hF, 32'h12345678);
    add_vec(1'b0, 10'd1023, 32'h00000000, 4'hF, 32'hCAFEF00D);
    add_vec(1'b0, 10'd0,    32'h00000000, 4'hF, 32'h00000001);
    add_vec(1'b1, 10'd9,    32'h11223344, 4'hF, 32'h00000001);
    add_vec(1'b0, 10'd9,    32'h00000000, 4'hF, 32'h11223344);
`ifdef DM_BYTE_WRITE_EN
    add_vec(1'b1, 10'd9,    32'hAABBCCDD, 4'b0101, 32'h11223344);
    add_vec(1'b0, 10'd9,    32'h00000000, 4'hF,    32'h11BB33DD);
    add_vec(1'b1, 10'd9,    32'h55667788, 4'b0000, 32'h11BB33DD);
    add_vec(1'b0, 10'd9,    32'h00000000, 4'hF,    32'h11BB33DD);
`endif
    for (int i = 0; i < vecs.size(); i++) run_txn(i, vecs[i]);

    // Read addr 5 while the bus is scribbled with a write of addr 6.
    drive_req(1'b0, 10'd5, 32'h0, 4'hF);
    @(posedge clk); #1;
    bus2.req = 1'b1; bus2.in = 1'b1; bus2.add_dm = 10'd6; bus2.dm_in = 32'hFFFFFFFF;
    acks = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (bus2.ack) acks++;
      if (k == 2) check("intf_dout", bus2.dm_out, 32'h12345678);
      if (k == 3) bus2.req = 1'b0;
    end
    check("intf_ack_count", 32'(acks), 32'd1);
    check("intf_dout_hold", bus2.dm_out, 32'h12345678);
    $display("txn intf RD addr=5 with bus changes, acks=%0d dm_out=%h", acks, bus2.dm_out);
    v.wr = 1'b0; v.addr = 10'd6; v.data = '0; v.be = 4'hF; v.exp_dout = 32'h0BADC0DE;
    run_txn(100, v);

    // Reset one cycle after acceptance aborts the write to addr 7.
    drive_req(1'b1, 10'd7, 32'hAAAA5555, 4'hF);
    @(posedge clk); #1;
    bus2.req = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(bus2.busy), 32'd0);
    check("abort_ack", 32'(bus2.ack), 32'd0);
    check("abort_dout", bus2.dm_out, 32'd0);
    @(negedge clk); reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus2.ack) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    $display("txn abort WR addr=7 data=aaaa5555 acks=%0d", acks);
    v.wr = 1'b0; v.addr = 10'd7; v.data = '0; v.be = 4'hF; v.exp_dout = 32'h77777777;
    run_txn(101, v);

    // Reset coinciding with the access edge suppresses the write to addr 8.
    drive_req(1'b1, 10'd8, 32'h12121212, 4'hF);
    @(posedge clk); #1;
    bus2.req = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("abort2_ack", 32'(bus2.ack), 32'd0);
    check("abort2_busy", 32'(bus2.busy), 32'd0);
    check("abort2_dout", bus2.dm_out, 32'd0);
    @(negedge clk); reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus2.ack) acks++;
    end
    check("abort2_no_ack", 32'(acks), 32'd0);
    $display("txn abort-at-access WR addr=8 data=12121212 acks=%0d", acks);
    v.wr = 1'b0; v.addr = 10'd8; v.data = '0; v.be = 4'hF; v.exp_dout = 32'h88888888;
    run_txn(102, v);

    // Back-to-back throughput at LATENCY=1 and LATENCY=15 with req held high.
    n1 = 0; n15 = 0;
    for (int i = 0; i < 8; i++) begin t1[i] = 0; t15[i] = 0; end
    @(negedge clk);
    bus1.req = 1'b1; bus15.req = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (bus1.ack && n1 < 8) begin t1[n1] = c; n1++; end
      if (bus15.ack && n15 < 8) begin t15[n15] = c; n15++; end
    end
    @(negedge clk);
    bus1.req = 1'b0; bus15.req = 1'b0;
    check("lat1_first_ack", 32'(t1[0]), 32'd2);
    check("lat1_gap_a", 32'(t1[1] - t1[0]), 32'd3);
    check("lat1_gap_b", 32'(t1[2] - t1[1]), 32'd3);
    check("lat1_ack_count", 32'(n1), 32'd8);
    check("lat15_first_ack", 32'(t15[0]), 32'd16);
    check("lat15_gap_a", 32'(t15[1] - t15[0]), 32'd17);
    check("lat15_gap_b", 32'(t15[2] - t15[1]), 32'd17);
    check("lat15_ack_count", 32'(n15), 32'd3);
    $display("txn throughput lat1 acks at %0d,%0d,%0d lat15 acks at %0d,%0d,%0d",
             t1[0], t1[1], t1[2], t15[0], t15[1], t15[2]);

    repeat (20) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
